// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch stage (I) and the
// MEM-stage data access (D). A requester raises its level request and is held
// in stall until the arbiter has completed its access. Completion is a
// one-cycle done pulse, with rdata (and err for a timed-out access) valid for
// that cycle.
//
// Each access walks IDLE -> BUSY -> DONE -> IDLE. When both requesters ask in
// the same IDLE cycle, the one that was not granted last time wins.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  maximum BUSY cycles before the access is abandoned (1..65535)
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   i_req, i_addr            instruction-fetch request (always a read)
//   d_req, d_we, d_addr,
//   d_wdata                  data-access request from the MEM stage
//   i_stall, d_stall         stall back to each requester
//   i_done, d_done           one-cycle completion pulse for the owner
//   rdata, err               read data / timeout flag, valid with a done pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata      command to the memory, held for the whole access
//   mem_ack, mem_rdata       one-cycle completion and read data from memory
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_stall,
  output logic              d_stall,
  output logic              i_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // The counter is sized for the largest legal TIMEOUT; it only ever reaches
  // TIMEOUT-1 before the access leaves BUSY.
  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                any_req;
  owner_e              grant;

  // Arbitration: a lone requester always wins; on a tie the requester that
  // was not granted last time goes first, giving strict alternation while
  // both keep asking.
  always_comb begin
    any_req = i_req | d_req;
    grant   = OWNER_I;
    if (i_req && d_req) begin
      grant = (last_owner_q == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_req) begin
      grant = OWNER_D;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a requester
  // still holding req during its own DONE cycle is not granted twice. mem_ack
  // is only meaningful in BUSY and is ignored elsewhere.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = BUSY;
          owner_d      = grant;
          last_owner_d = grant;
          cnt_d        = '0;
          if (grant == OWNER_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            // Instruction fetches are always reads.
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end

      BUSY: begin
        // An ack on the final allowed cycle still counts as success, so the
        // ack test comes before the timeout test.
        if (mem_ack) begin
          state_d = DONE;
          rdata_d = mem_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state. Reset forces IDLE immediately, which drops mem_req
  // without waiting for a clock edge. last_owner resets to I so that D wins
  // the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_I;
      last_owner_q <= OWNER_I;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  // Latched command and response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs. A stall is lifted only in the owner's DONE cycle, so a requester
  // that is waiting for arbitration sees stall for as long as it holds req.
  always_comb begin
    mem_req   = (state_q == BUSY);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_done    = (state_q == DONE) && (owner_q == OWNER_I);
    d_done    = (state_q == DONE) && (owner_q == OWNER_D);
    i_stall   = i_req && !i_done;
    d_stall   = d_req && !d_done;
    rdata     = rdata_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// The bench plays both requesters and the memory. Each round decides which
// requesters ask, what they ask for and how many BUSY cycles the memory takes
// to answer. A transaction-level model works out the grant order from the
// alternation rule and the expected outcome of each access, and queues the
// expected memory commands and done responses. A separate monitor acts as the
// memory, checks every command and done pulse against those queues and checks
// the stall outputs every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int TB_TIMEOUT = 4;
  localparam int WAIT_LIMIT = 60;
  localparam int N_RANDOM   = 80;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_stall;
  logic          d_stall;
  logic          i_done;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int testsRun  = 0;
  int failCount = 0;

  // Expected memory command, plus how the bench's memory will answer it.
  typedef struct {
    bit            isD;
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] data;
  } cmd_t;

  // Expected done pulse and the number of cycles mem_req should have been up.
  typedef struct {
    bit            isD;
    logic [DW-1:0] rdata;
    bit            err;
    int            busy;
  } resp_t;

  cmd_t  cmdQ[$];
  resp_t respQ[$];
  bit    modelLastD;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .i_stall  (i_stall),
    .d_stall  (d_stall),
    .i_done   (i_done),
    .d_done   (d_done),
    .rdata    (rdata),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Records one grant in the model: what the memory should see and what the
  // owner should get back. An ack later than TIMEOUT cycles never arrives.
  task automatic modelGrant(input bit isD, input logic [AW-1:0] addr, input bit we,
                            input logic [DW-1:0] wdata, input int delay, input logic [DW-1:0] data);
    cmd_t  c;
    resp_t r;
    c.isD = isD; c.addr = addr; c.we = we; c.wdata = wdata; c.delay = delay; c.data = data;
    cmdQ.push_back(c);
    r.isD = isD;
    if (delay <= TB_TIMEOUT) begin
      r.rdata = data; r.err = 1'b0; r.busy = delay;
    end else begin
      r.rdata = '0; r.err = 1'b1; r.busy = TB_TIMEOUT;
    end
    respQ.push_back(r);
    modelLastD = isD;
  endtask

  // One requester: raise req, optionally drop it while its access is in
  // flight, wait (bounded) for its done pulse, then release req after the
  // DONE cycle.
  task automatic runRequester(input bit isD, input logic [AW-1:0] addr, input bit we,
                              input logic [DW-1:0] wdata, input bit dropEarly);
    bit seen;
    seen = 1'b0;
    if (isD) begin
      d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    if (dropEarly) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      if (isD) d_req = 1'b0;
      else     i_req = 1'b0;
    end
    for (int cyc = 0; cyc < WAIT_LIMIT && !seen; cyc++) begin
      @(negedge clk);
      if (isD ? d_done : i_done) seen = 1'b1;
    end
    checkOutput(isD ? "d_done_within_limit" : "i_done_within_limit", 64'(seen), 64'(1));
    @(posedge clk);
    #1;
    if (isD) d_req = 1'b0;
    else     i_req = 1'b0;
  endtask

  // One round: the model decides the grant order, then both requesters run
  // concurrently. Called #1 after a rising edge with the DUT idle.
  task automatic applyStimulus(input bit reqI, input bit reqD,
                               input logic [AW-1:0] iAddr, input logic [AW-1:0] dAddr,
                               input bit dWe, input logic [DW-1:0] dWdata,
                               input int iDelay, input int dDelay,
                               input logic [DW-1:0] iData, input logic [DW-1:0] dData,
                               input bit dropEarly);
    bit dFirst;
    dFirst = reqD && (!reqI || !modelLastD);
    if (dFirst) begin
      modelGrant(1'b1, dAddr, dWe, dWdata, dDelay, dData);
      if (reqI) modelGrant(1'b0, iAddr, 1'b0, '0, iDelay, iData);
    end else begin
      if (reqI) modelGrant(1'b0, iAddr, 1'b0, '0, iDelay, iData);
      if (reqD) modelGrant(1'b1, dAddr, dWe, dWdata, dDelay, dData);
    end
    fork
      if (reqI) runRequester(1'b0, iAddr, 1'b0, '0, dropEarly && !reqD);
      if (reqD) runRequester(1'b1, dAddr, dWe, dWdata, dropEarly && !reqI);
    join
  endtask

  // Memory model and scoreboard monitor, sampling on the falling edge. It
  // answers each command after the queued number of BUSY cycles, drives
  // random ack noise while no request is up, and checks done pulses and
  // stalls.
  initial begin
    cmd_t  cur;
    resp_t r;
    int    busyCnt;
    int    lastBusy;
    bit    inBusy;
    busyCnt = 0; lastBusy = 0; inBusy = 1'b0;
    cur = '{isD: 1'b0, addr: '0, we: 1'b0, wdata: '0, delay: 0, data: '0};
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inBusy = 1'b0; busyCnt = 0; mem_ack = 1'b0;
      end else begin
        if (mem_req) begin
          if (!inBusy) begin
            inBusy = 1'b1; busyCnt = 1;
            checkOutput("cmd_expected", 64'(cmdQ.size() != 0), 64'(1));
            if (cmdQ.size() != 0) begin
              cur = cmdQ.pop_front();
              checkOutput("mem_addr", 64'(mem_addr), 64'(cur.addr));
              checkOutput("mem_we", 64'(mem_we), 64'(cur.we));
              if (cur.isD) checkOutput("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end else begin
              cur.delay = 0;
            end
          end else begin
            busyCnt++;
            checkOutput("mem_addr_stable", 64'(mem_addr), 64'(cur.addr));
          end
          if (busyCnt == cur.delay) begin
            mem_ack = 1'b1; mem_rdata = cur.data;
          end else begin
            mem_ack = 1'b0; mem_rdata = $urandom;
          end
        end else begin
          if (inBusy) begin
            lastBusy = busyCnt; inBusy = 1'b0;
          end
          mem_ack = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end

        if (i_done || d_done) begin
          checkOutput("done_expected", 64'(respQ.size() != 0), 64'(1));
          if (respQ.size() != 0) begin
            r = respQ.pop_front();
            checkOutput("done_owner", 64'({i_done, d_done}), 64'(r.isD ? 2'b01 : 2'b10));
            checkOutput("done_rdata", 64'(rdata), 64'(r.rdata));
            checkOutput("done_err", 64'(err), 64'(r.err));
            checkOutput("busy_cycles", 64'(lastBusy), 64'(r.busy));
          end
        end

        checkOutput("i_stall", 64'(i_stall), 64'(i_req && !i_done));
        checkOutput("d_stall", 64'(d_stall), 64'(d_req && !d_done));
      end
    end
  end

  // Main sequence: reset checks, directed rounds, reset during an access,
  // then randomized rounds.
  initial begin
    cmd_t c;
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    modelLastD = 1'b0;

    #12;
    checkOutput("rst_mem_req", 64'(mem_req), 64'(0));
    checkOutput("rst_i_done", 64'(i_done), 64'(0));
    checkOutput("rst_d_done", 64'(d_done), 64'(0));
    checkOutput("rst_err", 64'(err), 64'(0));
    checkOutput("rst_rdata", 64'(rdata), 64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("rst_i_stall", 64'(i_stall), 64'(1));
    checkOutput("rst_d_stall", 64'(d_stall), 64'(0));
    i_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tie straight after reset: D first, then I; repeated for D,I,D,I.
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 32'h0000_0200, 1'b0, 32'h0, 2, 1, 32'h1111_1111, 32'h2222_2222, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_2004, 32'h0000_0204, 1'b1, 32'hCAFE_F00D, 1, 3, 32'h3333_3333, 32'h4444_4444, 1'b0);
    // Single read answered in the third BUSY cycle.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_0100, 1'b0, 32'h0, 1, 3, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // No ack at all: timeout after TIMEOUT cycles with err and zero rdata.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_0300, 1'b1, 32'h5A5A_5A5A, 1, 99, 32'h0, 32'h7777_7777, 1'b0);
    // Ack on the last allowed cycle wins over the timeout.
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b0, 32'h0, TB_TIMEOUT, 1, 32'h8888_8888, 32'h0, 1'b0);
    // Minimum latency fetch, then a D access whose requester drops req early.
    applyStimulus(1'b1, 1'b0, 32'h0000_4004, 32'h0, 1'b0, 32'h0, 1, 1, 32'h9999_9999, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_0400, 1'b0, 32'h0, 1, 3, 32'h0, 32'hABCD_0123, 1'b1);

    // Reset in the middle of an access: mem_req must drop at once.
    c = '{isD: 1'b1, addr: 32'h0000_0500, we: 1'b0, wdata: '0, delay: 99, data: '0};
    cmdQ.push_back(c);
    d_req = 1'b1; d_addr = 32'h0000_0500; d_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("busy_before_reset", 64'(mem_req), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_mem_req", 64'(mem_req), 64'(0));
    checkOutput("rst_mid_d_done", 64'(d_done), 64'(0));
    checkOutput("rst_mid_err", 64'(err), 64'(0));
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cmdQ.delete();
    respQ.delete();
    modelLastD = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 32'h0000_6000, 32'h0000_0600, 1'b1, 32'h1234_5678, 2, 2, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0);

    // Randomized rounds.
    for (int n = 0; n < N_RANDOM; n++) begin
      int  pick, iDel, dDel, gap;
      bit  rI, rD, drop;
      pick = $urandom_range(1, 3);
      rI = pick[0];
      rD = pick[1];
      iDel = $urandom_range(1, 6);
      dDel = $urandom_range(1, 6);
      drop = (rI != rD) && ($urandom_range(0, 3) == 0) && ((rI ? iDel : dDel) >= 2);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(rI, rD, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    iDel, dDel, $urandom, $urandom, drop);
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("cmd_queue_drained", 64'(cmdQ.size()), 64'(0));
    checkOutput("resp_queue_drained", 64'(respQ.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Global bound on the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
